// File: rtl/static_buff_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : static_buff_sched_pkg
// Purpose  : Configuration, derived widths and state type for the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package static_buff_sched_pkg;

    localparam int NUMFIFO   = 8;
    localparam int NUMELEM   = 4;
    localparam int POP_DELAY = 2;
    localparam int NUMCRED   = 4;

    localparam int BITFIFO = $clog2(NUMFIFO);
    localparam int BITELEM = $clog2(NUMELEM);
    localparam int BITCRED = $clog2(NUMCRED + 1);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Round-robin successor, wrapping at NUMFIFO even when it is not a power of two.
    function automatic logic [BITFIFO-1:0] rr_next(input logic [BITFIFO-1:0] idx);
        return (idx == BITFIFO'(NUMFIFO - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/static_buff_sched_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb
// Purpose  : Combinational round-robin pick of the first request at or after ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         gnt_vld,
    output logic [W-1:0] gnt_idx
);

    always_comb begin
        int idx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!gnt_vld && req[idx[W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx[W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/static_buff_sched.sv
`default_nettype none
// ============================================================================
// Module   : static_buff_sched
// Purpose  : Push admission, round-robin credit-gated pop scheduling and
//            read-data strobe alignment for a multi-queue static buffer.
// Revision : 1.0 - initial release
// ============================================================================
module static_buff_sched
    import static_buff_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               buf_ready,
    input  logic               enable,
    input  logic               in_vld,
    input  logic [BITFIFO-1:0] in_prt,
    output logic               in_acc,
    output logic               push,
    output logic [BITFIFO-1:0] pu_prt,
    output logic               pop,
    output logic [BITFIFO-1:0] po_prt,
    output logic               out_vld,
    output logic [BITFIFO-1:0] out_prt,
    input  logic               cred_ret,
    output logic               cred_err
);

    localparam logic [BITELEM:0]   CNT_FULL  = (BITELEM + 1)'(NUMELEM);
    localparam logic [BITCRED-1:0] CRED_FULL = BITCRED'(NUMCRED);

    state_t               state_q, state_d;
    logic [BITELEM:0]     cnt_q [NUMFIFO];
    logic [BITELEM:0]     cnt_d [NUMFIFO];
    logic [BITCRED-1:0]   cred_q, cred_d;
    logic [BITFIFO-1:0]   rr_ptr_q, rr_ptr_d;
    logic                 cred_err_q, cred_err_d;
    logic [POP_DELAY-1:0] dly_vld_q, dly_vld_d;
    logic [BITFIFO-1:0]   dly_prt_q [POP_DELAY];
    logic [BITFIFO-1:0]   dly_prt_d [POP_DELAY];

    logic [NUMFIFO-1:0]   req;
    logic                 gnt_vld;
    logic [BITFIFO-1:0]   gnt_idx;

    // Registered counts only: a same-cycle push is never visible to the pop side.
    always_comb begin
        req = '0;
        for (int i = 0; i < NUMFIFO; i++) begin
            req[i] = (state_q == RUN) && (cnt_q[i] != '0) && (cred_q != '0);
        end
    end

    rr_arb #(
        .N (NUMFIFO),
        .W (BITFIFO)
    ) u_rr_arb (
        .req     (req),
        .ptr     (rr_ptr_q),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        in_acc   = in_vld && (state_q != INIT) && (cnt_q[in_prt] < CNT_FULL);
        push     = in_acc;
        pu_prt   = in_prt;
        pop      = gnt_vld;
        po_prt   = gnt_idx;
        out_vld  = dly_vld_q[POP_DELAY-1];
        out_prt  = dly_prt_q[POP_DELAY-1];
        cred_err = cred_err_q;
    end

    always_comb begin
        logic inc;
        logic dec;
        for (int i = 0; i < NUMFIFO; i++) begin
            inc      = push && (pu_prt == BITFIFO'(i));
            dec      = pop  && (po_prt == BITFIFO'(i));
            cnt_d[i] = cnt_q[i];
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end

        cred_d     = cred_q;
        cred_err_d = cred_err_q;
        if (pop && !cred_ret) begin
            cred_d = cred_q - 1'b1;
        end else if (cred_ret && !pop) begin
            if (cred_q == CRED_FULL) begin
                cred_err_d = 1'b1;
            end else begin
                cred_d = cred_q + 1'b1;
            end
        end

        rr_ptr_d = pop ? rr_next(gnt_idx) : rr_ptr_q;

        dly_vld_d[0] = pop;
        dly_prt_d[0] = po_prt;
        for (int k = 1; k < POP_DELAY; k++) begin
            dly_vld_d[k] = dly_vld_q[k-1];
            dly_prt_d[k] = dly_prt_q[k-1];
        end

        state_d = state_q;
        case (state_q)
            INIT:    if (buf_ready) state_d = RUN;
            RUN:     if (!buf_ready) state_d = INIT;
                     else if (!enable) state_d = PAUSE;
            PAUSE:   if (!buf_ready) state_d = INIT;
                     else if (enable) state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            cred_q     <= CRED_FULL;
            rr_ptr_q   <= '0;
            cred_err_q <= 1'b0;
            dly_vld_q  <= '0;
            for (int i = 0; i < NUMFIFO; i++) begin
                cnt_q[i] <= '0;
            end
            for (int k = 0; k < POP_DELAY; k++) begin
                dly_prt_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cred_q     <= cred_d;
            rr_ptr_q   <= rr_ptr_d;
            cred_err_q <= cred_err_d;
            dly_vld_q  <= dly_vld_d;
            cnt_q      <= cnt_d;
            dly_prt_q  <= dly_prt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_static_buff_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_static_buff_sched
// Purpose  : Directed vector table, corner sequences and random stimulus
//            against a queue-level reference model of the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_static_buff_sched;
    import static_buff_sched_pkg::*;

    localparam int ST_INIT  = 0;
    localparam int ST_RUN   = 1;
    localparam int ST_PAUSE = 2;

    logic               clk = 1'b0;
    logic               rst, buf_ready, enable, in_vld, cred_ret;
    logic [BITFIFO-1:0] in_prt;
    logic               in_acc, push, pop, out_vld, cred_err;
    logic [BITFIFO-1:0] pu_prt, po_prt, out_prt;

    int n_cmp = 0;
    int n_err = 0;

    static_buff_sched dut (
        .clk       (clk),
        .rst       (rst),
        .buf_ready (buf_ready),
        .enable    (enable),
        .in_vld    (in_vld),
        .in_prt    (in_prt),
        .in_acc    (in_acc),
        .push      (push),
        .pu_prt    (pu_prt),
        .pop       (pop),
        .po_prt    (po_prt),
        .out_vld   (out_vld),
        .out_prt   (out_prt),
        .cred_ret  (cred_ret),
        .cred_err  (cred_err)
    );

    always #5 clk = ~clk;

    // Reference model: per-queue occupancy, credit pool and a queue of in-flight pops.
    int m_cnt [NUMFIFO];
    int m_cred, m_rr, m_st;
    bit m_err;
    bit m_known = 1'b0;
    int m_pipe [$];

    bit e_acc, e_pop, e_ov;
    int e_po, e_op;

    logic               s_acc, s_pop, s_ovld;
    logic [BITFIFO-1:0] s_po, s_oprt;

    typedef struct {
        bit rst; bit br; bit en; bit vld; int prt; bit ret;
        bit chk; bit e_acc; bit e_pop; int e_po; bit e_ov;
    } vec_t;
    vec_t tbl [17];

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_cred = NUMCRED;
        m_rr   = 0;
        m_st   = ST_INIT;
        m_err  = 1'b0;
        m_pipe = {};
        repeat (POP_DELAY) m_pipe.push_back(-1);
    endtask

    task automatic model_eval();
        e_acc = in_vld && (m_st != ST_INIT) && (m_cnt[int'(in_prt)] < NUMELEM);
        e_pop = 1'b0;
        e_po  = 0;
        if (m_st == ST_RUN && m_cred > 0) begin
            for (int k = 0; k < NUMFIFO; k++) begin
                int q;
                q = (m_rr + k) % NUMFIFO;
                if (!e_pop && m_cnt[q] > 0) begin
                    e_pop = 1'b1;
                    e_po  = q;
                end
            end
        end
        e_op = m_pipe[POP_DELAY-1];
        e_ov = (e_op >= 0);
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
            m_known = 1'b1;
            return;
        end
        if (e_acc) m_cnt[int'(in_prt)]++;
        if (e_pop) m_cnt[e_po]--;
        if (e_pop && !cred_ret) m_cred--;
        else if (cred_ret && !e_pop) begin
            if (m_cred == NUMCRED) m_err = 1'b1;
            else m_cred++;
        end
        if (e_pop) m_rr = (e_po + 1) % NUMFIFO;
        if (m_st == ST_INIT) begin
            if (buf_ready) m_st = ST_RUN;
        end else if (!buf_ready) m_st = ST_INIT;
        else if (m_st == ST_RUN && !enable) m_st = ST_PAUSE;
        else if (m_st == ST_PAUSE && enable) m_st = ST_RUN;
        m_pipe.push_front(e_pop ? e_po : -1);
        void'(m_pipe.pop_back());
    endtask

    task automatic drive(input bit r, input bit br, input bit en, input bit v,
                         input int p, input bit ret);
        rst       = r;
        buf_ready = br;
        enable    = en;
        in_vld    = v;
        in_prt    = BITFIFO'(p);
        cred_ret  = ret;
    endtask

    // One clock: sample and compare on the falling edge, advance the model on the rising edge.
    task automatic tick();
        @(negedge clk);
        model_eval();
        s_acc  = in_acc;
        s_pop  = pop;
        s_po   = po_prt;
        s_ovld = out_vld;
        s_oprt = out_prt;
        if (m_known) begin
            check("in_acc", int'(in_acc), int'(e_acc));
            check("push", int'(push), int'(e_acc));
            if (e_acc) check("pu_prt", int'(pu_prt), int'(in_prt));
            check("pop", int'(pop), int'(e_pop));
            if (e_pop) check("po_prt", int'(po_prt), e_po);
            check("out_vld", int'(out_vld), int'(e_ov));
            if (e_ov) check("out_prt", int'(out_prt), e_op);
            check("cred_err", int'(cred_err), int'(m_err));
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        int na, np;
        int ord [3];
        bit rec_pop [9];
        bit rec_ov [9];
        int rec_po [9];
        int rec_op [9];

        ord[0] = 1; ord[1] = 3; ord[2] = 6;
        model_reset();

        //             rst br en vld prt ret chk acc pop po ov
        tbl[0]  = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 1, 1, 2, 0, 1, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 0, 1, 5, 0, 1, 0, 0, 0, 0};
        tbl[4]  = '{0, 1, 0, 1, 5, 0, 1, 1, 0, 0, 0};
        tbl[5]  = '{0, 1, 0, 1, 5, 0, 1, 1, 0, 0, 0};
        tbl[6]  = '{0, 1, 0, 1, 5, 0, 1, 1, 0, 0, 0};
        tbl[7]  = '{0, 1, 0, 1, 5, 0, 1, 1, 0, 0, 0};
        tbl[8]  = '{0, 1, 0, 1, 5, 0, 1, 0, 0, 0, 0};
        tbl[9]  = '{0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0};
        tbl[10] = '{0, 1, 1, 0, 0, 0, 1, 0, 1, 5, 0};
        tbl[11] = '{0, 1, 1, 0, 0, 0, 1, 0, 1, 5, 0};
        tbl[12] = '{0, 1, 1, 0, 0, 0, 1, 0, 1, 5, 1};
        tbl[13] = '{0, 1, 1, 0, 0, 0, 1, 0, 1, 5, 1};
        tbl[14] = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 1};
        tbl[15] = '{0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1};
        tbl[16] = '{0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0};

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].br, tbl[i].en, tbl[i].vld, tbl[i].prt, tbl[i].ret);
            tick();
            if (tbl[i].chk) begin
                check($sformatf("tbl%0d_acc", i), int'(s_acc), int'(tbl[i].e_acc));
                check($sformatf("tbl%0d_pop", i), int'(s_pop), int'(tbl[i].e_pop));
                if (tbl[i].e_pop) check($sformatf("tbl%0d_po", i), int'(s_po), tbl[i].e_po);
                check($sformatf("tbl%0d_ovld", i), int'(s_ovld), int'(tbl[i].e_ov));
            end
        end

        // Credit return while the pool is already full.
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 1, 0, 0, 1);
            tick();
            if (k == 2) check("cred_err_before_full", int'(cred_err), 0);
        end
        check("cred_err_at_full_ret", int'(cred_err), 1);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 1, 0, 0, 0);
            tick();
        end
        check("cred_err_sticky", int'(cred_err), 1);

        // Pause accepts pushes but never pops; then credit-limited draining.
        na = 0; np = 0;
        for (int k = 0; k < 6; k++) begin
            drive(0, 1, 0, 1, (k < 4) ? 0 : 7, 0);
            tick();
            na += int'(s_acc);
            np += int'(s_pop);
        end
        check("pause_acc_count", na, 6);
        check("pause_pop_count", np, 0);
        drive(0, 1, 1, 0, 0, 0);
        tick();
        check("pause_exit_pop", int'(s_pop), 0);
        np = 0;
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 1, 0, 0, 0);
            tick();
            np += int'(s_pop);
        end
        check("cred_stall_pops", np, NUMCRED);
        drive(0, 1, 1, 0, 0, 1);
        tick();
        check("ret_cycle_pop", int'(s_pop), 0);
        np = 0;
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 1, 0, 0, 0);
            tick();
            np += int'(s_pop);
        end
        check("one_pop_per_credit", np, 1);

        // Queue 0 holds one entry, no credit: same-cycle push/pop and ret/pop.
        drive(0, 1, 1, 1, 0, 1);
        tick();
        check("simul_setup_acc", int'(s_acc), 1);
        check("simul_setup_pop", int'(s_pop), 0);
        drive(0, 1, 1, 1, 0, 1);
        tick();
        check("simul_acc", int'(s_acc), 1);
        check("simul_pop", int'(s_pop), 1);
        check("simul_po", int'(s_po), 0);
        drive(0, 1, 1, 0, 0, 0);
        tick();
        check("cred_held_on_ret_and_pop", int'(s_pop), 1);
        np = 0;
        for (int k = 0; k < 6; k++) begin
            drive(0, 1, 1, 0, 0, 1);
            tick();
            np += int'(s_pop);
        end
        check("cnt_kept_on_push_pop", np, 1);

        // Reset with a pop in flight and queue 3 still occupied.
        drive(0, 1, 1, 1, 3, 0);
        tick();
        check("pre_rst_acc", int'(s_acc), 1);
        drive(0, 1, 1, 1, 3, 0);
        tick();
        check("inflight_pop", int'(s_pop), 1);
        check("inflight_po", int'(s_po), 3);
        drive(1, 1, 1, 0, 0, 0);
        tick();
        check("rst_out_vld", int'(out_vld), 0);
        check("rst_cred_err", int'(cred_err), 0);
        drive(0, 0, 1, 0, 0, 0);
        tick();
        check("rst_pipe_flushed", int'(s_ovld), 0);

        // Round-robin order and read-strobe alignment.
        drive(0, 1, 0, 0, 0, 0);
        tick();
        na = 0;
        for (int k = 0; k < 6; k++) begin
            drive(0, 1, 0, 1, ord[k % 3], 0);
            tick();
            na += int'(s_acc);
        end
        check("order_fill_acc", na, 6);
        drive(0, 1, 1, 0, 0, 0);
        tick();
        for (int k = 0; k < 9; k++) begin
            drive(0, 1, 1, 0, 0, k < 6);
            tick();
            rec_pop[k] = s_pop;
            rec_po[k]  = int'(s_po);
            rec_ov[k]  = s_ovld;
            rec_op[k]  = int'(s_oprt);
        end
        for (int k = 0; k < 9; k++) begin
            check($sformatf("order_pop%0d", k), int'(rec_pop[k]), int'(k < 6));
            if (k < 6) check($sformatf("order_po%0d", k), rec_po[k], ord[k % 3]);
            check($sformatf("order_ovld%0d", k), int'(rec_ov[k]), int'(k >= 2 && k < 8));
            if (k >= 2 && k < 8) check($sformatf("order_oprt%0d", k), rec_op[k], ord[(k - 2) % 3]);
        end

        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 97,
                  $urandom_range(0, 99) < 90, $urandom_range(0, 99) < 60,
                  int'($urandom_range(0, NUMFIFO - 1)), $urandom_range(0, 99) < 40);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
